// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between two requesters, the shared memory port
// and mem_arbiter.
//   Requester N (N=0,1): I_reqN, I_weN, I_addrN, I_wdataN in; O_doneN, O_errN out
//   Shared return:       O_rdata (read data), O_grant (one-hot owner)
//   Memory side:         O_mem_execute/we/addr/wdata out; I_mem_ready,
//                        I_data_ready, I_mem_data in
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          I_req0;
  logic          I_we0;
  logic [AW-1:0] I_addr0;
  logic [DW-1:0] I_wdata0;
  logic          O_done0;
  logic          O_err0;

  logic          I_req1;
  logic          I_we1;
  logic [AW-1:0] I_addr1;
  logic [DW-1:0] I_wdata1;
  logic          O_done1;
  logic          O_err1;

  logic [DW-1:0] O_rdata;
  logic [1:0]    O_grant;

  logic          O_mem_execute;
  logic          O_mem_we;
  logic [AW-1:0] O_mem_addr;
  logic [DW-1:0] O_mem_wdata;
  logic          I_mem_ready;
  logic          I_data_ready;
  logic [DW-1:0] I_mem_data;

  modport slave (
    input  I_req0, I_we0, I_addr0, I_wdata0,
    input  I_req1, I_we1, I_addr1, I_wdata1,
    input  I_mem_ready, I_data_ready, I_mem_data,
    output O_done0, O_err0, O_done1, O_err1,
    output O_rdata, O_grant,
    output O_mem_execute, O_mem_we, O_mem_addr, O_mem_wdata
  );

  modport master (
    output I_req0, I_we0, I_addr0, I_wdata0,
    output I_req1, I_we1, I_addr1, I_wdata1,
    output I_mem_ready, I_data_ready, I_mem_data,
    input  O_done0, O_err0, O_done1, O_err1,
    input  O_rdata, O_grant,
    input  O_mem_execute, O_mem_we, O_mem_addr, O_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for two requesters (0 = CPU, 1 = DMA /
// debug loader) sharing one memory port. Serialises accesses through
// IDLE -> ISSUE -> WAIT -> DONE, drives the execute/ready handshake and
// returns done, read data and a watchdog timeout error to the owner.
// Ports:
//   I_clk      rising-edge clock
//   I_reset_n  synchronous active-low reset
//   bus        mem_arbiter_if.slave (requester, return and memory signals)
// Parameters: AW/DW address/data width, TIMEOUT max WAIT cycles (1..65535).
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         I_clk,
  input  logic         I_reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [16:0] TMO = 17'(TIMEOUT);

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          owner_q;
  logic          busy_seen_q;
  logic          err_q;
  logic [15:0]   wd_q;
  logic [1:0]    grant_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  logic          any_req;
  logic          win;
  logic [16:0]   wd_inc;
  logic          timed_out;
  logic          rd_done;
  logic          wr_done;
  logic          complete;

  logic          exec;
  logic          done0, done1, err0, err1;

  assign any_req   = bus.I_req0 | bus.I_req1;
  // Sole requester wins; on a tie the one that did not go last wins.
  assign win       = (bus.I_req0 && bus.I_req1) ? ~last_grant_q : bus.I_req1;
  assign wd_inc    = {1'b0, wd_q} + 17'd1;
  assign timed_out = (wd_inc >= TMO);
  // Reads finish on data valid; writes need memory to have gone busy and
  // come back, so a stale ready right after the strobe is not taken.
  assign rd_done   = !mem_we_q && bus.I_data_ready;
  assign wr_done   = mem_we_q && bus.I_mem_ready && busy_seen_q;
  assign complete  = rd_done || wr_done;

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    exec    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    err0    = 1'b0;
    err1    = 1'b0;
    case (state_q)
      S_IDLE:  if (any_req && bus.I_mem_ready) state_d = S_ISSUE;
      S_ISSUE: begin
        exec    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  if (complete || timed_out) state_d = S_DONE;
      S_DONE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        err0    = ~owner_q & err_q;
        err1    = owner_q & err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      busy_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      wd_q         <= '0;
      grant_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req && bus.I_mem_ready) begin
            owner_q     <= win;
            grant_q     <= win ? 2'b10 : 2'b01;
            mem_we_q    <= win ? bus.I_we1    : bus.I_we0;
            mem_addr_q  <= win ? bus.I_addr1  : bus.I_addr0;
            mem_wdata_q <= win ? bus.I_wdata1 : bus.I_wdata0;
          end
        end
        S_ISSUE: begin
          busy_seen_q <= 1'b0;
          wd_q        <= '0;
          err_q       <= 1'b0;
        end
        S_WAIT: begin
          wd_q <= wd_inc[15:0];
          if (!bus.I_mem_ready) busy_seen_q <= 1'b1;
          if (complete) begin
            if (rd_done) rdata_q <= bus.I_mem_data;
          end else if (timed_out) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_DONE: begin
          last_grant_q <= owner_q;
          grant_q      <= '0;
          mem_we_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.O_mem_execute = exec;
  assign bus.O_mem_we      = mem_we_q;
  assign bus.O_mem_addr    = mem_addr_q;
  assign bus.O_mem_wdata   = mem_wdata_q;
  assign bus.O_grant       = grant_q;
  assign bus.O_rdata       = rdata_q;
  assign bus.O_done0       = done0;
  assign bus.O_done1       = done1;
  assign bus.O_err0        = err0;
  assign bus.O_err1        = err1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter (TIMEOUT=8).
module tb_mem_arbiter;

  logic I_clk;
  logic I_reset_n;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .I_clk    (I_clk),
    .I_reset_n(I_reset_n),
    .bus      (bus.slave)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wd0, wd1, mem_rd;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [15:0] exp_addr, exp_wdata, exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, 32'(bus.O_grant), 0);
    chk({tag, ".exec"},  32'(bus.O_mem_execute), 0);
    chk({tag, ".done"},  32'({bus.O_done0, bus.O_done1}), 0);
    chk({tag, ".err"},   32'({bus.O_err0, bus.O_err1}), 0);
    chk({tag, ".rdata"}, 32'(bus.O_rdata), 0);
    chk({tag, ".we"},    32'(bus.O_mem_we), 0);
    chk({tag, ".addr"},  32'(bus.O_mem_addr), 0);
    chk({tag, ".wdata"}, 32'(bus.O_mem_wdata), 0);
  endtask

  // Entered with the DUT observed in ISSUE; completes a read for requester n.
  task automatic finish_read(input string tag, input int n, input logic [15:0] data);
    step();
    bus.I_data_ready = 1'b1;
    bus.I_mem_data   = data;
    step();
    bus.I_data_ready = 1'b0;
    chk({tag, ".done0"}, 32'(bus.O_done0), 32'(n == 0));
    chk({tag, ".done1"}, 32'(bus.O_done1), 32'(n == 1));
    chk({tag, ".err"},   32'({bus.O_err0, bus.O_err1}), 0);
    chk({tag, ".rdata"}, 32'(bus.O_rdata), 32'(data));
    step();
    chk({tag, ".idle_grant"}, 32'(bus.O_grant), 0);
  endtask

  // Memory model per vector: first WAIT cycle has data valid and ready low,
  // so reads end there while writes end one cycle later when ready returns.
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    bus.I_req0 = v.req0; bus.I_we0 = v.we0; bus.I_addr0 = v.addr0; bus.I_wdata0 = v.wd0;
    bus.I_req1 = v.req1; bus.I_we1 = v.we1; bus.I_addr1 = v.addr1; bus.I_wdata1 = v.wd1;
    bus.I_mem_ready = 1'b1; bus.I_data_ready = 1'b0;
    step();
    chk({t, ".exec"},  32'(bus.O_mem_execute), 1);
    chk({t, ".grant"}, 32'(bus.O_grant), 32'(v.exp_grant));
    chk({t, ".we"},    32'(bus.O_mem_we), 32'(v.exp_we));
    chk({t, ".addr"},  32'(bus.O_mem_addr), 32'(v.exp_addr));
    chk({t, ".wdata"}, 32'(bus.O_mem_wdata), 32'(v.exp_wdata));
    step();
    chk({t, ".exec_wait"}, 32'(bus.O_mem_execute), 0);
    bus.I_data_ready = 1'b1; bus.I_mem_ready = 1'b0; bus.I_mem_data = v.mem_rd;
    step();
    bus.I_data_ready = 1'b0; bus.I_mem_ready = 1'b1;
    if (v.exp_we) begin
      chk({t, ".no_early_done"}, 32'({bus.O_done0, bus.O_done1}), 0);
      step();
    end
    chk({t, ".done0"}, 32'(bus.O_done0), 32'(v.exp_grant[0]));
    chk({t, ".done1"}, 32'(bus.O_done1), 32'(v.exp_grant[1]));
    chk({t, ".err"},   32'({bus.O_err0, bus.O_err1}), 0);
    if (!v.exp_we) chk({t, ".rdata"}, 32'(bus.O_rdata), 32'(v.exp_rdata));
    step();
    chk({t, ".idle_grant"}, 32'(bus.O_grant), 0);
    chk({t, ".idle_done"},  32'({bus.O_done0, bus.O_done1}), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0200, 16'hA000, 16'hB000, 16'h1111, 2'b01, 1'b0, 16'h0100, 16'hA000, 16'h1111};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0101, 16'h0201, 16'hA001, 16'hB001, 16'h2222, 2'b10, 1'b0, 16'h0201, 16'hB001, 16'h2222};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0102, 16'h0202, 16'hA002, 16'hB002, 16'h3333, 2'b01, 1'b0, 16'h0102, 16'hA002, 16'h3333};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0103, 16'h0203, 16'hA003, 16'hB003, 16'h4444, 2'b10, 1'b0, 16'h0203, 16'hB003, 16'h4444};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h8000, 16'h0000, 16'h1234, 16'h0000, 2'b10, 1'b1, 16'h8000, 16'h1234, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 16'h5555, 2'b10, 1'b0, 16'h8001, 16'h0000, 16'h5555};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'hCAFE, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h0002, 16'hCAFE, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0004, 16'hDEAD, 16'hBEEF, 16'h7777, 2'b10, 1'b0, 16'h0004, 16'hBEEF, 16'h7777};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 2'b01, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};

    bus.I_req0 = 0; bus.I_we0 = 0; bus.I_addr0 = '0; bus.I_wdata0 = '0;
    bus.I_req1 = 0; bus.I_we1 = 0; bus.I_addr1 = '0; bus.I_wdata1 = '0;
    bus.I_mem_ready = 1; bus.I_data_ready = 0; bus.I_mem_data = '0;
    I_reset_n = 0;
    step();
    step();
    chk_all_zero("reset");
    I_reset_n = 1;
    step();

    // Table: tie fairness 0,1,0,1 then sole requesters, write, boundary address.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Single read; requester drops and changes address after grant.
    bus.I_req0 = 1; bus.I_we0 = 0; bus.I_addr0 = 16'h0040;
    bus.I_req1 = 0; bus.I_mem_ready = 1; bus.I_data_ready = 0;
    step();
    chk("rd.exec", 32'(bus.O_mem_execute), 1);
    chk("rd.grant", 32'(bus.O_grant), 32'h1);
    bus.I_req0 = 0; bus.I_addr0 = 16'h1111;
    step();
    chk("rd.addr_held", 32'(bus.O_mem_addr), 32'h0040);
    step();
    bus.I_data_ready = 1; bus.I_mem_data = 16'hBEEF;
    step();
    bus.I_data_ready = 0;
    chk("rd.done0", 32'(bus.O_done0), 1);
    chk("rd.done1", 32'(bus.O_done1), 0);
    chk("rd.err0", 32'(bus.O_err0), 0);
    chk("rd.rdata", 32'(bus.O_rdata), 32'hBEEF);
    step();
    chk("rd.idle_done", 32'(bus.O_done0), 0);
    chk("rd.idle_addr", 32'(bus.O_mem_addr), 32'h0040);

    // Write with an early ready pulse, then 3 busy cycles.
    bus.I_req1 = 1; bus.I_we1 = 1; bus.I_addr1 = 16'h8000; bus.I_wdata1 = 16'h1234;
    step();
    chk("wr.grant", 32'(bus.O_grant), 32'h2);
    chk("wr.we", 32'(bus.O_mem_we), 1);
    chk("wr.wdata", 32'(bus.O_mem_wdata), 32'h1234);
    chk("wr.addr", 32'(bus.O_mem_addr), 32'h8000);
    bus.I_req1 = 0; bus.I_wdata1 = 16'hFFFF;
    step();
    bus.I_mem_ready = 1;
    step();
    chk("wr.early_ready", 32'(bus.O_done1), 0);
    bus.I_mem_ready = 0;
    step();
    chk("wr.busy1", 32'(bus.O_done1), 0);
    step();
    chk("wr.busy2", 32'(bus.O_done1), 0);
    step();
    chk("wr.busy3", 32'(bus.O_done1), 0);
    bus.I_mem_ready = 1;
    step();
    chk("wr.done1", 32'(bus.O_done1), 1);
    chk("wr.err1", 32'(bus.O_err1), 0);
    chk("wr.done0", 32'(bus.O_done0), 0);
    chk("wr.wdata_held", 32'(bus.O_mem_wdata), 32'h1234);
    step();
    chk("wr.idle_we", 32'(bus.O_mem_we), 0);

    // Memory busy when the request arrives.
    bus.I_req0 = 1; bus.I_we0 = 0; bus.I_addr0 = 16'h0010; bus.I_mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy.no_exec", 32'(bus.O_mem_execute), 0);
    end
    bus.I_mem_ready = 1;
    step();
    chk("busy.exec", 32'(bus.O_mem_execute), 1);
    chk("busy.grant", 32'(bus.O_grant), 32'h1);
    bus.I_req0 = 0;
    finish_read("busy", 0, 16'h5A5A);

    // Watchdog: read never answered, requester 1 waits behind it.
    bus.I_req0 = 1; bus.I_we0 = 0; bus.I_addr0 = 16'h0020;
    step();
    chk("tmo.exec", 32'(bus.O_mem_execute), 1);
    bus.I_req0 = 0; bus.I_req1 = 1; bus.I_we1 = 0; bus.I_addr1 = 16'h0030;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) chk("tmo.early_done", 32'(bus.O_done0), 0);
    end
    chk("tmo.done0", 32'(bus.O_done0), 1);
    chk("tmo.err0", 32'(bus.O_err0), 1);
    chk("tmo.err1", 32'(bus.O_err1), 0);
    chk("tmo.rdata", 32'(bus.O_rdata), 0);
    step();
    chk("tmo.idle_grant", 32'(bus.O_grant), 0);
    step();
    chk("tmo.next_exec", 32'(bus.O_mem_execute), 1);
    chk("tmo.next_grant", 32'(bus.O_grant), 32'h2);
    chk("tmo.next_addr", 32'(bus.O_mem_addr), 32'h0030);
    bus.I_req1 = 0;
    finish_read("tmo_next", 1, 16'h0C0C);

    // Make requester 0 the last owner so a tie would go to 1 without reset.
    bus.I_req0 = 1; bus.I_addr0 = 16'h0050;
    step();
    bus.I_req0 = 0;
    finish_read("pre_rst", 0, 16'h6666);

    // Reset during WAIT abandons the access.
    bus.I_req0 = 1; bus.I_addr0 = 16'h0060;
    step();
    bus.I_req0 = 0;
    step();
    I_reset_n = 0;
    step();
    chk_all_zero("rst_mid");
    I_reset_n = 1;
    bus.I_req0 = 1; bus.I_req1 = 1; bus.I_we0 = 0; bus.I_we1 = 0;
    step();
    chk("rst_mid.tie_grant", 32'(bus.O_grant), 32'h1);
    bus.I_req0 = 0; bus.I_req1 = 0;
    finish_read("rst_mid", 0, 16'h9999);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single memory port between the CPU (requester 0, driven by the control unit's fetch and load/store phases) and a secondary master (requester 1: DMA or debug loader).
- Serialises accesses, drives the memory execute/ready handshake, and returns completion, read data and a timeout error to the granted requester.
- Round-robin priority with a watchdog so a silent memory cannot hang the CPU.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 255, max WAIT cycles before abort (1..65535)

Ports:
I_clk  in  1  clock, rising edge
I_reset_n  in  1  synchronous reset, active low
I_req0  in  1  requester 0 access request (level)
I_we0  in  1  requester 0 write (1) / read (0)
I_addr0  in  AW  requester 0 address
I_wdata0  in  DW  requester 0 write data
O_done0  out  1  requester 0 completion pulse
O_err0  out  1  requester 0 timeout, valid with O_done0
I_req1, I_we1, I_addr1, I_wdata1, O_done1, O_err1: same as requester 0, for requester 1
O_rdata  out  DW  read data, valid in O_doneN cycle
O_grant  out  2  one-hot current owner, 00 when idle
O_mem_execute  out  1  one-cycle memory start strobe
O_mem_we  out  1  write enable to memory
O_mem_addr  out  AW  memory address
O_mem_wdata  out  DW  memory write data
I_mem_ready  in  1  memory idle/accepting
I_data_ready  in  1  memory read data valid
I_mem_data  in  DW  memory read data

Behaviour:
- Reset (I_reset_n=0 at a clock edge): state IDLE; all outputs 0; last_grant=1 (requester 0 wins the first tie); watchdog=0. Applies mid-transaction; the in-flight access is abandoned and no done is pulsed.
- States: IDLE, ISSUE, WAIT, DONE; one transition per clock.
- IDLE:
  - When (I_req0|I_req1) && I_mem_ready: pick the winner. A sole requester wins; on a tie the requester not equal to last_grant wins.
  - Latch we/addr/wdata into O_mem_we/O_mem_addr/O_mem_wdata, set O_grant, go to ISSUE.
  - If I_mem_ready=0, stay in IDLE.
- ISSUE: O_mem_execute=1 for exactly this cycle; clear busy_seen and watchdog; go to WAIT. Request-to-strobe latency: 1 cycle after the request is sampled.
- WAIT:
  - watchdog increments each cycle; busy_seen is set on any cycle with I_mem_ready=0.
  - Read completes on the first cycle with I_data_ready=1: latch I_mem_data into O_rdata, go to DONE.
  - Write completes on the first cycle with I_mem_ready=1 && busy_seen=1. A ready pulse in the WAIT cycle immediately after ISSUE does not complete a write unless busy_seen is set.
  - If watchdog reaches TIMEOUT before completion: set err, go to DONE, O_rdata=0.
- DONE:
  - O_doneN=1 for the granted N only, and O_errN=err, for one cycle.
  - last_grant=N; O_grant=00; O_mem_we=0; return to IDLE.
  - The earliest next grant is the following cycle, so back-to-back accesses take at least 4 cycles each.
- Addr/we/wdata are registered at grant; requester changes after grant are ignored. Dropping I_reqN mid-transaction does not abort; O_doneN is still pulsed.
- A requester holding I_req high continuously alternates with the other when both request (fairness).
- O_mem_addr/O_mem_wdata hold their last values while idle; O_mem_execute is never asserted outside ISSUE.
- Reads ignore I_mem_ready in WAIT; writes ignore I_data_ready.

Test Plan:
- Single read: I_req0=1, I_we0=0, I_addr0=0x0040; memory returns 0xBEEF with I_data_ready two cycles after execute -> O_mem_execute at cycle 2, O_done0 with O_rdata=0xBEEF at cycle 5, O_err0=0, O_done1 never asserted.
- Write handshake: I_req1 write 0x1234 to 0x8000; I_mem_ready=1 in the first WAIT cycle, 0 for 3 cycles, then 1 -> no completion on the early ready; O_done1 in the cycle after ready returns; O_mem_we=1, O_mem_wdata=0x1234.
- Tie fairness: after reset, I_req0=I_req1=1 held for 4 accesses with reads completing at once -> grant order 0,1,0,1.
- Timeout: TIMEOUT=8, read with I_data_ready never asserted -> O_done0=1 and O_err0=1 exactly 8 cycles after the WAIT entry, O_rdata=0, arbiter back to IDLE and accepting requester 1 next.
- Mem busy at request: I_mem_ready=0 for 5 cycles while I_req0=1 -> no O_mem_execute until ready rises, then ISSUE the next cycle.
- Reset mid-op: assert I_reset_n=0 during WAIT -> next edge all outputs 0, no done pulse; after release a tied request goes to requester 0.
